// File: rtl/keypad_pkg.sv
// Shared defaults and width helpers for the keypad matrix scanner.
package keypad_pkg;

    localparam int DEF_ROWS            = 4;
    localparam int DEF_COLS            = 4;
    localparam int DEF_SCAN_DIV        = 5000;
    localparam int DEF_DEBOUNCE_FRAMES = 4;

    // Width of a key index; never narrower than one bit.
    function automatic int key_idx_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    // Width of a counter holding 0..n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-frame debouncer: commits a new key map after DEBOUNCE_FRAMES identical frames,
// unless the event emitter is still draining the previous change.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] frame,
    input  logic             frame_strobe,
    input  logic             hold,
    output logic [WIDTH-1:0] key_state,
    output logic [WIDTH-1:0] change,
    output logic             commit
);

    localparam int SW = cnt_w(DEBOUNCE_FRAMES);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES - 1);

    logic [WIDTH-1:0] prev;
    logic [SW-1:0]    stable;
    logic [SW-1:0]    stable_nxt;

    always_comb begin
        stable_nxt = '0;
        if (frame == prev) begin
            stable_nxt = (stable == STABLE_MAX) ? stable : stable + 1'b1;
        end
        // A held commit is retried at every later frame end; stable stays saturated.
        commit = frame_strobe && (stable_nxt == STABLE_MAX) && (frame != key_state) && !hold;
        change = frame ^ key_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            stable    <= '0;
            key_state <= '0;
        end else if (frame_strobe) begin
            prev   <= frame;
            stable <= stable_nxt;
            if (commit) begin
                key_state <= frame;
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_scan.sv
// Matrix keypad scanner: one-cold row strobe, frame assembly, debounce and a
// valid/ready key-event stream (lowest changed index first).
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int ROWS            = DEF_ROWS,
    parameter int COLS            = DEF_COLS,
    parameter int SCAN_DIV        = DEF_SCAN_DIV,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [COLS-1:0]                     col,
    output logic [ROWS-1:0]                     row,
    output logic [ROWS*COLS-1:0]                key_state,
    output logic                                evt_valid,
    input  logic                                evt_ready,
    output logic [key_idx_w(ROWS, COLS)-1:0]    evt_code,
    output logic                                evt_press
);

    localparam int N  = ROWS * COLS;
    localparam int KW = key_idx_w(ROWS, COLS);
    localparam int CW = cnt_w(SCAN_DIV);
    localparam int RW = cnt_w(ROWS);
    localparam logic [CW-1:0]   SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
    localparam logic [ROWS-1:0] ROW_INIT  = {{(ROWS-1){1'b1}}, 1'b0};

    logic [CW-1:0] slot_cnt;
    logic [RW-1:0] row_idx;
    logic [N-1:0]  raw;
    logic [N-1:0]  frame;
    logic [N-1:0]  pending;
    logic [N-1:0]  rem;
    logic [N-1:0]  fire_mask;
    logic [N-1:0]  change;
    logic [KW-1:0] first_idx;
    logic          sample;
    logic          frame_end;
    logic          commit;

    assign sample    = (slot_cnt == SLOT_LAST);
    assign frame_end = sample && (row_idx == ROW_LAST);

    // The frame seen at frame end includes the row being sampled right now.
    always_comb begin
        frame = raw;
        frame[int'(row_idx)*COLS +: COLS] = ~col;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            row_idx  <= '0;
            row      <= ROW_INIT;
            raw      <= '0;
        end else if (sample) begin
            slot_cnt <= '0;
            raw      <= frame;
            row      <= {row[ROWS-2:0], row[ROWS-1]};
            row_idx  <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    keypad_debounce #(
        .WIDTH           (N),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame        (frame),
        .frame_strobe (frame_end),
        .hold         (|pending),
        .key_state    (key_state),
        .change       (change),
        .commit       (commit)
    );

    // Valid/ready: an event transfers on a clk edge where evt_valid and evt_ready are
    // both 1; while evt_valid=1 and evt_ready=0, evt_code/evt_press do not change.
    always_comb begin
        fire_mask = '0;
        if (evt_valid && evt_ready) begin
            fire_mask[evt_code] = 1'b1;
        end
        rem       = pending & ~fire_mask;
        first_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rem[i]) first_idx = KW'(i);
        end
    end

    // Commit only happens with pending empty, so rem is zero whenever change is merged in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_press <= 1'b0;
        end else begin
            pending   <= commit ? (rem | change) : rem;
            evt_valid <= |rem;
            evt_code  <= first_idx;
            evt_press <= key_state[first_idx];
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan: 4x3 matrix, SCAN_DIV=4, DEBOUNCE_FRAMES=3.
module tb_keypad_matrix_scan;

    localparam int ROWS  = 4;
    localparam int COLS  = 3;
    localparam int N     = ROWS * COLS;
    localparam int KW    = 4;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            evt_ready = 1'b1;
    logic [N-1:0]    pressed   = '0;
    logic [COLS-1:0] col;
    logic [ROWS-1:0] row;
    logic [N-1:0]    key_state;
    logic            evt_valid;
    logic [KW-1:0]   evt_code;
    logic            evt_press;

    int total = 0;
    int bad   = 0;
    int cyc;
    int fs;
    int nhold;
    int nks;
    logic [4:0] exp_q[$];
    logic [4:0] exp_e;

    always #5 clk = ~clk;

    keypad_matrix_scan #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_state (key_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_press (evt_press)
    );

    // Ideal switch matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!row[r] && pressed[r*COLS + c]) col[c] = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [ROWS-1:0] exp_row(input int c);
        logic [ROWS-1:0] r;
        r = '1;
        r[(c / 4) % ROWS] = 1'b0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic align_frame();
        while (cyc % 16 != 0) tick();
    endtask

    task automatic push_evt(input logic press, input int code);
        exp_q.push_back({press, 4'(code)});
    endtask

    // Scoreboard: every accepted event must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("evt_extra", 32'({evt_press, evt_code}), 32'h3f);
            end else begin
                exp_e = exp_q.pop_front();
                check("evt_seq", 32'({evt_press, evt_code}), 32'(exp_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Reset state and scan sweep with no keys.
        tick();
        tick();
        check("rst_row", 32'(row), 32'hE);
        check("rst_ks", 32'(key_state), 32'h0);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_code", 32'(evt_code), 32'h0);
        check("rst_press", 32'(evt_press), 32'h0);
        rst_n = 1'b1;
        nks = 0;
        for (int i = 0; i < 32; i++) begin
            check("sweep_row", 32'(row), 32'(exp_row(cyc)));
            if (key_state != '0 || evt_valid) nks++;
            tick();
        end
        check("sweep_idle", nks, 0);

        // Single press of key (2,1) = index 7, then release.
        align_frame();
        fs = cyc;
        pressed = 12'h080;
        push_evt(1'b1, 7);
        wait_cyc(fs + 47);
        check("sp_ks_before", 32'(key_state), 32'h0);
        tick();
        check("sp_ks_commit", 32'(key_state), 32'h080);
        check("sp_valid_lag", 32'(evt_valid), 32'h0);
        tick();
        check("sp_valid", 32'(evt_valid), 32'h1);
        check("sp_code", 32'(evt_code), 32'h7);
        check("sp_press", 32'(evt_press), 32'h1);
        tick();
        check("sp_valid_drop", 32'(evt_valid), 32'h0);
        align_frame();
        fs = cyc;
        pressed = '0;
        push_evt(1'b0, 7);
        wait_cyc(fs + 48);
        check("sr_ks", 32'(key_state), 32'h0);
        tick();
        check("sr_valid", 32'(evt_valid), 32'h1);
        check("sr_code", 32'(evt_code), 32'h7);
        check("sr_press", 32'(evt_press), 32'h0);

        // Bounce: key 7 toggles for 5 frames, then held pressed.
        align_frame();
        fs = cyc;
        nhold = 0;
        nks = 0;
        push_evt(1'b1, 7);
        for (int i = 0; i < 111; i++) begin
            if (i % 16 == 0) pressed = ((i / 16) < 5 && (i / 16) % 2 == 1) ? 12'h000 : 12'h080;
            tick();
            if (evt_valid) nhold++;
            if (key_state != '0) nks++;
        end
        check("bn_no_evt", nhold, 0);
        check("bn_no_commit", nks, 0);
        tick();
        check("bn_ks", 32'(key_state), 32'h080);
        tick();
        check("bn_code", 32'({evt_valid, evt_press, evt_code}), 32'h37);
        align_frame();
        fs = cyc;
        pressed = '0;
        push_evt(1'b0, 7);
        wait_cyc(fs + 50);
        check("bn_rel_ks", 32'(key_state), 32'h0);
        check("bn_rel_idle", 32'(evt_valid), 32'h0);

        // Simultaneous press of keys 0, 5, 11; events on consecutive cycles.
        align_frame();
        fs = cyc;
        pressed = 12'h821;
        push_evt(1'b1, 0);
        push_evt(1'b1, 5);
        push_evt(1'b1, 11);
        wait_cyc(fs + 48);
        check("sim_ks", 32'(key_state), 32'h821);
        check("sim_valid_lag", 32'(evt_valid), 32'h0);
        tick();
        check("sim_e0", 32'({evt_valid, evt_press, evt_code}), 32'h30);
        tick();
        check("sim_e1", 32'({evt_valid, evt_press, evt_code}), 32'h35);
        tick();
        check("sim_e2", 32'({evt_valid, evt_press, evt_code}), 32'h3B);
        tick();
        check("sim_end", 32'(evt_valid), 32'h0);
        align_frame();
        fs = cyc;
        pressed = '0;
        push_evt(1'b0, 0);
        push_evt(1'b0, 5);
        push_evt(1'b0, 11);
        wait_cyc(fs + 52);
        check("sim_rel_ks", 32'(key_state), 32'h0);
        check("sim_rel_end", 32'(evt_valid), 32'h0);

        // Back-pressure: keys 1 and 4 change, ready low 50 frames, key 9 changes meanwhile.
        align_frame();
        fs = cyc;
        evt_ready = 1'b0;
        pressed = 12'h012;
        push_evt(1'b1, 1);
        push_evt(1'b1, 4);
        wait_cyc(fs + 49);
        check("bp_first", 32'({evt_valid, evt_press, evt_code}), 32'h31);
        nhold = 0;
        nks = 0;
        while (cyc < fs + 800) begin
            if (cyc == fs + 160) pressed = 12'h212;
            tick();
            if (!(evt_valid && evt_code == 4'd1 && evt_press)) nhold++;
            if (key_state != 12'h012) nks++;
        end
        check("bp_held", nhold, 0);
        check("bp_deferred", nks, 0);
        evt_ready = 1'b1;
        push_evt(1'b1, 9);
        tick();
        check("bp_second", 32'({evt_valid, evt_press, evt_code}), 32'h34);
        tick();
        check("bp_drained", 32'(evt_valid), 32'h0);
        wait_cyc(fs + 815);
        check("bp_ks_before", 32'(key_state), 32'h012);
        tick();
        check("bp_ks_retry", 32'(key_state), 32'h212);
        tick();
        check("bp_third", 32'({evt_valid, evt_press, evt_code}), 32'h39);

        // Async reset while an event is waiting.
        align_frame();
        fs = cyc;
        evt_ready = 1'b0;
        pressed = '0;
        wait_cyc(fs + 49);
        check("ar_pending", 32'({evt_valid, evt_press, evt_code}), 32'h21);
        wait_cyc(fs + 60);
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(evt_valid), 32'h0);
        check("ar_ks", 32'(key_state), 32'h0);
        check("ar_row", 32'(row), 32'hE);
        tick();
        tick();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        nks = 0;
        for (int i = 0; i < 20; i++) begin
            check("ar_row_restart", 32'(row), 32'(exp_row(cyc)));
            if (key_state != '0 || evt_valid) nks++;
            tick();
        end
        check("ar_quiet", nks, 0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
